flit_arb_mux: RTL

//  Parametrised N:1 flit multiplexer for the NoC router output stage. Replaces the fixed
//  2:1 sel-driven mux with internal wormhole arbitration. One input is granted per packet
//  (HEAD..TAIL) and held until its TAIL has transferred. Output is registered with a

---
 rtl/flit_arb_mux.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/flit_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : flit_arb_mux
// Description : N:1 wormhole flit multiplexer with round-robin or fixed
//               priority arbitration on HEAD flits and a registered
//               valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module flit_arb_mux #(
  parameter int NPORT    = 4,
  parameter int DATAW    = 66,
  parameter int VCHW     = 2,
  parameter int ARB_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT*DATAW-1:0] idata,
  input  logic [NPORT-1:0]       ivalid,
  input  logic [NPORT*VCHW-1:0]  ivch,
  output logic [NPORT-1:0]       iready,
  output logic [DATAW-1:0]       odata,
  output logic                   ovalid,
  output logic [VCHW-1:0]        ovch,
  input  logic                   oready,
  output logic [NPORT-1:0]       grant,
  output logic                   perr
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_DATA = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NPORT-1:0]  grant_q, grant_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic              head_seen_q, head_seen_d;
  logic [DATAW-1:0]  odata_q, odata_d;
  logic [VCHW-1:0]   ovch_q, ovch_d;
  logic              ovalid_q, ovalid_d;
  logic              perr_q, perr_d;

  logic [NPORT-1:0]  w_req;
  logic              w_win_found;
  logic [PW-1:0]     w_win_idx;
  logic [DATAW-1:0]  w_gflit;
  logic [1:0]        w_gtype;
  logic [VCHW-1:0]   w_gvch;
  logic              w_xfer;
  logic [PW-1:0]     w_rr_next;

  // Only a valid HEAD flit may request ownership of the output.
  generate
    for (genvar k = 0; k < NPORT; k++) begin : g_req
      assign w_req[k] = ivalid[k] & (idata[k*DATAW + DATAW-2 +: 2] == FT_HEAD);
    end
  endgenerate

  // Port visited at scan step i: rotated from the rr pointer, or plain index.
  function automatic int scan_idx(input int i, input logic [PW-1:0] ptr);
    if (ARB_MODE != 0) return i;
    return (int'(ptr) + i) % NPORT;
  endfunction

  // Pick the first requester in scan order.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (!w_win_found && w_req[scan_idx(i, rr_q)]) begin
        w_win_found = 1'b1;
        w_win_idx   = PW'(scan_idx(i, rr_q));
      end
    end
  end

  assign w_gflit   = idata[int'(gidx_q)*DATAW +: DATAW];
  assign w_gtype   = w_gflit[DATAW-1 -: 2];
  assign w_gvch    = ivch[int'(gidx_q)*VCHW +: VCHW];
  assign w_xfer    = (state_q == S_LOCKED) & ivalid[gidx_q] & (~ovalid_q | oready);
  assign w_rr_next = (int'(gidx_q) == NPORT-1) ? '0 : gidx_q + PW'(1);
  // grant_q is zero while idle, so no port is ever ready outside LOCKED.
  assign iready    = grant_q & {NPORT{w_xfer}};

  // Next-state: arbitration in IDLE, flit forwarding and error detection in LOCKED.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_d        = rr_q;
    head_seen_d = head_seen_q;
    odata_d     = odata_q;
    ovch_d      = ovch_q;
    ovalid_d    = ovalid_q;
    perr_d      = 1'b0;

    // Output drains when accepted; a new transfer below overrides this.
    if (ovalid_q && oready) ovalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_win_found) begin
          state_d              = S_LOCKED;
          grant_d              = '0;
          grant_d[w_win_idx]   = 1'b1;
          gidx_d               = w_win_idx;
          head_seen_d          = 1'b0;
        end
      end
      S_LOCKED: begin
        if (w_xfer) begin
          odata_d  = w_gflit;
          ovch_d   = w_gvch;
          ovalid_d = 1'b1;
          // Second HEAD, or body/tail before the HEAD, is flagged but still forwarded.
          if (w_gtype == FT_HEAD) begin
            if (head_seen_q) perr_d = 1'b1;
            head_seen_d = 1'b1;
          end else if ((w_gtype == FT_DATA) || (w_gtype == FT_TAIL)) begin
            if (!head_seen_q) perr_d = 1'b1;
          end
          if (w_gtype == FT_TAIL) begin
            state_d = S_IDLE;
            grant_d = '0;
            rr_d    = w_rr_next;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; an in-flight packet is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_q        <= '0;
      head_seen_q <= 1'b0;
      odata_q     <= '0;
      ovch_q      <= '0;
      ovalid_q    <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_q        <= rr_d;
      head_seen_q <= head_seen_d;
      odata_q     <= odata_d;
      ovch_q      <= ovch_d;
      ovalid_q    <= ovalid_d;
      perr_q      <= perr_d;
    end
  end

  assign odata  = odata_q;
  assign ovch   = ovch_q;
  assign ovalid = ovalid_q;
  assign grant  = grant_q;
  assign perr   = perr_q;

endmodule
`default_nettype wire
